// File: rtl/huffman_decoder_if.sv
// Host bus bundle for the Huffman decoder (Avalon-MM style slave).
//
// Handshake: the host qualifies every access with chipselect. A write
// (chipselect & write) is taken at the rising clock edge; the side flags
// table_write / length_write / last_word select what writedata carries.
// A read (chipselect & read) returns the FIFO head combinationally on
// readdata and pops it at the same edge when the FIFO is non-empty.
// Data writes must only be issued while busy_out is low.
//
// Signals:
//   chipselect, write, read         host strobes
//   writedata[31:0]                 table entry / length value / encoded word
//   table_write, length_write       write qualifiers
//   last_word                       marks the final encoded word
//   readdata[31:0]                  {done, overflow, error, valid, symbol}
//   empty_out, busy_out             status
interface huffman_decoder_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic        table_write;
  logic        length_write;
  logic        last_word;
  logic [31:0] readdata;
  logic        empty_out;
  logic        busy_out;

  modport master (
    output chipselect, write, read, writedata, table_write, length_write, last_word,
    input  readdata, empty_out, busy_out
  );

  modport slave (
    input  chipselect, write, read, writedata, table_write, length_write, last_word,
    output readdata, empty_out, busy_out
  );
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder.
//
// Encoded 32-bit words are shifted MSB first into a candidate register and
// compared each cycle against a 64-entry {code, length} table. Matched
// symbols are queued in an output FIFO that the host drains via reads.
//
// Ports:
//   clock      system clock
//   resetn     asynchronous active-low reset
//   bus        host interface (slave modport), see huffman_decoder_if
//   dbg_state  current FSM state (IDLE=0, DECODE=1, STALL=2, DONE=3)
module huffman_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               resetn,
  huffman_decoder_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [31:0] word_q,     word_d;
  logic [5:0]  bit_cnt_q,  bit_cnt_d;
  logic        final_q,    final_d;
  logic [5:0]  len_val_q,  len_val_d;
  logic [7:0]  cand_q,     cand_d;
  logic [3:0]  cand_len_q, cand_len_d;
  logic        err_q,      err_d;
  logic        ovf_q,      ovf_d;

  logic [7:0]  tcode_q [64];
  logic [7:0]  tcode_d [64];
  logic [3:0]  tlen_q  [64];
  logic [3:0]  tlen_d  [64];

  logic [5:0]  fifo_q  [FIFO_DEPTH];
  logic [5:0]  fifo_d  [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic        fifo_empty, fifo_full;
  logic        data_wr, pop;
  logic [7:0]  cand_nxt;
  logic [3:0]  cand_len_nxt;
  logic [8:0]  mask_w;
  logic        match;
  logic [5:0]  match_sym;

  // Bits of the host word that carry no meaning, and the candidate MSB which
  // is always shifted out.
  logic unused_bits;
  assign unused_bits = ^{bus.writedata[31:18], cand_q[7]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign data_wr = bus.chipselect & bus.write & ~bus.table_write & ~bus.length_write;
  assign pop     = bus.chipselect & bus.read & ~fifo_empty;

  assign cand_nxt     = {cand_q[6:0], word_q[31]};
  assign cand_len_nxt = cand_len_q + 4'd1;
  assign mask_w       = (9'd1 << cand_len_nxt) - 9'd1;

  // Parallel compare against all valid entries. Scanning from the top down
  // lets the lowest matching index overwrite any higher one.
  always_comb begin
    match     = 1'b0;
    match_sym = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if ((tlen_q[i] != 4'd0) && (tlen_q[i] == cand_len_nxt) &&
          (((tcode_q[i] ^ cand_nxt) & mask_w[7:0]) == 8'd0)) begin
        match     = 1'b1;
        match_sym = 6'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    final_d    = final_q;
    len_val_d  = len_val_q;
    cand_d     = cand_q;
    cand_len_d = cand_len_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    tcode_d    = tcode_q;
    tlen_d     = tlen_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (bus.chipselect && bus.write && bus.length_write)
      len_val_d = bus.writedata[5:0];

    if (data_wr && (state_q != S_IDLE))
      ovf_d = 1'b1;

    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.chipselect && bus.write && bus.table_write) begin
          tlen_d[bus.writedata[5:0]]  = bus.writedata[9:6];
          tcode_d[bus.writedata[5:0]] = bus.writedata[17:10];
        end
        if (data_wr) begin
          word_d  = bus.writedata;
          final_d = bus.last_word;
          if (bus.last_word)
            bit_cnt_d = (len_val_q == 6'd0) ? 6'd32 : len_val_q;
          else
            bit_cnt_d = 6'd32;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // A completed code with nowhere to go holds the bit in place.
        if (match && fifo_full && !pop) begin
          state_d = S_STALL;
        end else begin
          word_d    = {word_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 6'd1;
          if (match) begin
            fifo_d[wr_ptr_q[AW-1:0]] = match_sym;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            cand_d     = 8'd0;
            cand_len_d = 4'd0;
          end else if (cand_len_nxt == 4'd8) begin
            err_d      = 1'b1;
            cand_d     = 8'd0;
            cand_len_d = 4'd0;
          end else begin
            cand_d     = cand_nxt;
            cand_len_d = cand_len_nxt;
          end
          if (bit_cnt_q == 6'd1) begin
            if (final_q) begin
              state_d = S_DONE;
              // Stream ended inside a code.
              if (!match && (cand_len_nxt != 4'd8))
                err_d = 1'b1;
            end else begin
              // Partial candidate carries over into the next word.
              state_d = S_IDLE;
            end
          end
        end
      end

      S_STALL: begin
        if (!fifo_full || pop)
          state_d = S_DECODE;
      end

      default: ; // S_DONE holds until reset
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      final_q    <= 1'b0;
      len_val_q  <= '0;
      cand_q     <= '0;
      cand_len_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < 64; i++) begin
        tcode_q[i] <= '0;
        tlen_q[i]  <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_cnt_q  <= bit_cnt_d;
      final_q    <= final_d;
      len_val_q  <= len_val_d;
      cand_q     <= cand_d;
      cand_len_q <= cand_len_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tcode_q    <= tcode_d;
      tlen_q     <= tlen_d;
      fifo_q     <= fifo_d;
    end
  end

  assign bus.readdata  = {20'd0, (state_q == S_DONE), ovf_q, err_q, ~fifo_empty, 2'b00,
                          (fifo_empty ? 6'd0 : fifo_q[rd_ptr_q[AW-1:0]])};
  assign bus.empty_out = fifo_empty;
  assign bus.busy_out  = (state_q == S_DECODE) || (state_q == S_STALL);
  assign dbg_state     = state_q;

endmodule
